key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter KEY_W, default 4, number of independent push-buttons handled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, stable-level qualification time in clk cycles (20 ms at 50 MHz); legal range 2..2^24.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_n  input  KEY_W  raw asynchronous board buttons, active-low (0 = pressed).
REQ-006 key_state  output  KEY_W  debounced level per key, 1 = pressed.
REQ-007 key_press  output  KEY_W  one-cycle pulse per key on qualified press.
REQ-008 key_release  output  KEY_W  one-cycle pulse per key on qualified release.

Function
REQ-009 Each key_n bit SHALL pass a 2-flop synchronizer; the filter SHALL use only the synchronized bit s.
REQ-010 Each key SHALL have its own 4-state FSM: IDLE, PRESS_FILT, DOWN, REL_FILT; no state is shared between keys.
REQ-011 IDLE: s==0 -> PRESS_FILT, cnt cleared to 0; otherwise stay.
REQ-012 PRESS_FILT: s==1 -> IDLE, cnt cleared (bounce rejected, no pulse); s==0 -> cnt increments; when s==0 and cnt==DEBOUNCE_CYCLES-1 -> DOWN.
REQ-013 DOWN: s==1 -> REL_FILT, cnt cleared; otherwise stay.
REQ-014 REL_FILT: s==0 -> DOWN, cnt cleared (no pulse); s==1 -> cnt increments; when s==1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
REQ-015 key_state SHALL be registered, 1 exactly while FSM is in DOWN or REL_FILT.
REQ-016 key_press SHALL be high for exactly the one cycle in which key_state goes from 0 to 1; key_release for the one cycle in which it goes from 1 to 0; both pulses are never high together for one key.
REQ-017 Latency: a clean level change on key_n SHALL produce the corresponding key_state change and pulse DEBOUNCE_CYCLES+3 clk cycles later (2 sync + DEBOUNCE_CYCLES filter + 1 output register).
REQ-018 Any glitch shorter than DEBOUNCE_CYCLES cycles on s SHALL cause no change on any output.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap, only clear on state transitions.
REQ-020 Simultaneous events on several keys SHALL be handled independently and may pulse in the same cycle.

Reset
REQ-021 With rst==1 at a clk edge: synchronizer flops SHALL load 1 (released), all FSMs IDLE, all cnt 0, key_state, key_press, key_release all 0.
REQ-022 Reset asserted mid-filter or while DOWN SHALL abort without emitting key_release; after reset a held key SHALL be re-qualified and emit key_press once after DEBOUNCE_CYCLES+3 cycles.

Structure
REQ-023 Shared package key_pkg SHALL hold the FSM state enumeration (2-bit encoding IDLE=0, PRESS_FILT=1, DOWN=2, REL_FILT=3).
REQ-024 A single-key sub-module key_filter (synchronizer, counter, FSM, output register) SHALL be instantiated KEY_W times by a generate loop in key_debounce.
REQ-025 key_debounce outputs SHALL drive the key input of the downstream LED controller directly (key_press used as the LED event strobe).

Verification (bench overrides DEBOUNCE_CYCLES=10, clk period 20 ns)
REQ-026 rst high 190 ns then low, key_n=4'hF -> all outputs 0 throughout.
REQ-027 key_n[0] driven 0 and held -> key_press[0] single pulse and key_state[0]=1 exactly 13 cycles after the drop; no other bits change.
REQ-028 key_n[1] low for 5 cycles then high, repeated 4 times -> no pulses, key_state[1] stays 0.
REQ-029 key_n[0] pressed (qualified) then released with 3 bounces of 4 cycles each, then held high -> exactly one key_release[0], 13 cycles after the last rising edge.
REQ-030 key_n[3:2] dropped in the same cycle -> key_press[3] and key_press[2] pulse in the same cycle.
REQ-031 rst asserted 5 cycles after key_n[0] qualified while still held -> outputs clear, no key_release[0]; after rst release key_press[0] pulses once 13 cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types for the push-button debouncer.
// Holds the per-key filter FSM state encoding.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

endpackage

// File: rtl/key_filter.sv
// Single-key debouncer: 2-flop sync, stability counter, 4-state FSM.
// Ports: clk, rst (sync, high), key_n (raw, low=pressed), key_state, key_press, key_release.
module key_filter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt;
  key_fsm_e      state;

  assign s = sync[1];

  // Resets to 1 so a released button reads as released immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], key_n};
    end
  end

  // Outputs are assigned on the transition itself, so key_state
  // and the pulses are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!s) begin
            state <= PRESS_FILT;
            cnt   <= '0;
          end
        end
        PRESS_FILT: begin
          if (s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state     <= DOWN;
            cnt       <= '0;
            key_state <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOWN: begin
          if (s) begin
            state <= REL_FILT;
            cnt   <= '0;
          end
        end
        REL_FILT: begin
          if (!s) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debouncer for KEY_W active-low push-buttons, one key_filter per key.
// Ports: clk, rst, key_n[KEY_W], key_state/key_press/key_release[KEY_W].
module key_debounce #(
  parameter int KEY_W           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_n,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    key_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule
